// File: rtl/uart_pkg.sv
// Shared UART definitions: start-of-frame byte, frame error codes, parser states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

  localparam logic [7:0] SOF_DEFAULT = 8'hAA;

  // Error codes reported on o_ErrCode; 00 means no error has been seen since reset.
  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_CHK  = 2'b01;
  localparam logic [1:0] ERR_LEN  = 2'b10;
  localparam logic [1:0] ERR_TMO  = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CMD     = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHK     = 3'd4,
    ST_HOLD    = 3'd5
  } frame_state_t;

  // States in which the parser is waiting for the next byte of a frame body;
  // only these are subject to the inter-byte timeout.
  function automatic logic frame_timed(input frame_state_t s);
    return (s == ST_CMD) || (s == ST_LEN) || (s == ST_PAYLOAD) || (s == ST_CHK);
  endfunction

endpackage

// File: rtl/uart_frame_timer.sv
// Inter-byte watchdog: counts idle clocks while enabled, flags expiry at TIMEOUT-1.
// Latency: o_Expired is combinational from the count register; count clears in 1 clock.
// Backpressure: none; a clear in the expiry cycle suppresses the expiry.
module uart_frame_timer #(
  parameter int TIMEOUT = 50_000
) (
  input  logic i_Clk,
  input  logic i_Rst,
  input  logic i_Clr,
  input  logic i_En,
  output logic o_Expired
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: restart on any byte or when disabled, saturate at the expiry value.
  always_comb begin
    cnt_d = cnt_q;
    if (i_Clr || !i_En) begin
      cnt_d = '0;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Idle-clock counter register.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_Expired = i_En && !i_Clr && (cnt_q == LAST);

endmodule

// File: rtl/uart_frame_parser.sv
// Extracts SOF/CMD/LEN/payload/CHK frames from the UART RX byte stream and holds good ones.
// Latency: o_fValid 1 clock after the CHK strobe; errors 1 clock after the offending strobe/expiry.
// Backpressure: none upstream; bytes arriving while a frame is held are dropped and flagged on o_fOvr.
module uart_frame_parser
  import uart_pkg::*;
#(
  parameter logic [7:0] SOF     = SOF_DEFAULT,
  parameter int         MAX_LEN = 16,
  parameter int         TIMEOUT = 50_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_fByte,
  input  logic [7:0] i_Byte,
  input  logic       i_Ack,
  input  logic [7:0] i_RdAddr,
  output logic       o_fValid,
  output logic [7:0] o_Cmd,
  output logic [7:0] o_Len,
  output logic [7:0] o_RdData,
  output logic       o_fErr,
  output logic [1:0] o_ErrCode,
  output logic       o_fOvr
);

  localparam int         IDX_W     = $clog2(MAX_LEN + 1);
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  frame_state_t     state_q;
  logic [7:0]       cmd_q;
  logic [7:0]       len_q;
  logic [7:0]       xor_q;
  logic [IDX_W-1:0] idx_q;
  logic             valid_q;
  logic             err_q;
  logic [1:0]       code_q;
  logic             ovr_q;
  logic [7:0]       buf_q [MAX_LEN];

  logic             tmo_en;
  logic             tmo_expired;
  logic             wr_en;
  logic [7:0]       idx_plus1;
  logic [7:0]       rd_data;

  assign tmo_en    = frame_timed(state_q);
  assign wr_en     = i_fByte && (state_q == ST_PAYLOAD);
  assign idx_plus1 = 8'(idx_q) + 8'd1;

  uart_frame_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .i_Clk     (i_Clk),
    .i_Rst     (i_Rst),
    .i_Clr     (i_fByte),
    .i_En      (tmo_en),
    .o_Expired (tmo_expired)
  );

  // Frame FSM: walks the frame fields, checks length and checksum, holds good frames for the consumer.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      state_q <= ST_IDLE;
      cmd_q   <= '0;
      len_q   <= '0;
      xor_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      code_q  <= ERR_NONE;
      ovr_q   <= 1'b0;
    end else begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (i_fByte && (i_Byte == SOF)) begin
            state_q <= ST_CMD;
          end
        end
        ST_CMD: begin
          if (i_fByte) begin
            cmd_q   <= i_Byte;
            xor_q   <= i_Byte;
            state_q <= ST_LEN;
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TMO;
            state_q <= ST_IDLE;
          end
        end
        ST_LEN: begin
          if (i_fByte) begin
            if (i_Byte > MAX_LEN_B) begin
              err_q   <= 1'b1;
              code_q  <= ERR_LEN;
              state_q <= ST_IDLE;
            end else begin
              len_q   <= i_Byte;
              xor_q   <= xor_q ^ i_Byte;
              idx_q   <= '0;
              state_q <= (i_Byte == 8'd0) ? ST_CHK : ST_PAYLOAD;
            end
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TMO;
            state_q <= ST_IDLE;
          end
        end
        ST_PAYLOAD: begin
          if (i_fByte) begin
            xor_q <= xor_q ^ i_Byte;
            idx_q <= idx_q + IDX_W'(1);
            if (idx_plus1 == len_q) begin
              state_q <= ST_CHK;
            end
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TMO;
            state_q <= ST_IDLE;
          end
        end
        ST_CHK: begin
          if (i_fByte) begin
            if (i_Byte == xor_q) begin
              valid_q <= 1'b1;
              state_q <= ST_HOLD;
            end else begin
              err_q   <= 1'b1;
              code_q  <= ERR_CHK;
              state_q <= ST_IDLE;
            end
          end else if (tmo_expired) begin
            err_q   <= 1'b1;
            code_q  <= ERR_TMO;
            state_q <= ST_IDLE;
          end
        end
        ST_HOLD: begin
          // A byte arriving with the ack is treated as the first byte seen in IDLE.
          if (i_Ack) begin
            valid_q <= 1'b0;
            state_q <= (i_fByte && (i_Byte == SOF)) ? ST_CMD : ST_IDLE;
          end else if (i_fByte) begin
            ovr_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Payload buffer: written only while collecting payload, so it stays frozen during HOLD.
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        buf_q[i] <= '0;
      end
    end else if (wr_en) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        if (idx_q == IDX_W'(i)) begin
          buf_q[i] <= i_Byte;
        end
      end
    end
  end

  // Payload read port; addresses past the buffer read as zero.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if (i_RdAddr == 8'(i)) begin
        rd_data = buf_q[i];
      end
    end
  end

  assign o_fValid  = valid_q;
  assign o_Cmd     = cmd_q;
  assign o_Len     = len_q;
  assign o_RdData  = rd_data;
  assign o_fErr    = err_q;
  assign o_ErrCode = code_q;
  assign o_fOvr    = ovr_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Bench for uart_frame_parser: directed frame scenarios plus randomized frames vs a frame-rule model.
// Latency: expects valid/errors one clock after the deciding byte, timeout TMO clocks after the last byte.
// Backpressure: exercises hold overrun and ack-with-byte handover.
module tb_uart_frame_parser;

  localparam int MAXL = 16;
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fbyte = 1'b0;
  logic [7:0] byte_v = 8'h00;
  logic       ack = 1'b0;
  logic [7:0] rd_addr = 8'h00;

  logic       o_fValid;
  logic [7:0] o_Cmd;
  logic [7:0] o_Len;
  logic [7:0] o_RdData;
  logic       o_fErr;
  logic [1:0] o_ErrCode;
  logic       o_fOvr;

  int total = 0;
  int bad = 0;
  int err_pulses = 0;
  int ovr_pulses = 0;
  logic [1:0] last_err = 2'b00;

  uart_frame_parser #(
    .SOF     (8'hAA),
    .MAX_LEN (MAXL),
    .TIMEOUT (TMO)
  ) dut (
    .i_Clk     (clk),
    .i_Rst     (rst_n),
    .i_fByte   (fbyte),
    .i_Byte    (byte_v),
    .i_Ack     (ack),
    .i_RdAddr  (rd_addr),
    .o_fValid  (o_fValid),
    .o_Cmd     (o_Cmd),
    .o_Len     (o_Len),
    .o_RdData  (o_RdData),
    .o_fErr    (o_fErr),
    .o_ErrCode (o_ErrCode),
    .o_fOvr    (o_fOvr)
  );

  always #5 clk = ~clk;

  // Pulse counters, sampled just after each rising edge.
  always @(posedge clk) begin
    #1;
    if (o_fErr) err_pulses++;
    if (o_fOvr) ovr_pulses++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  // Called at a falling edge; presents one byte strobe, then idles for gap cycles.
  task automatic send_byte(input logic [7:0] b, input int gap);
    fbyte = 1'b1;
    byte_v = b;
    @(negedge clk);
    fbyte = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_frame1(input int gap);
    send_byte(8'hAA, gap); send_byte(8'h10, gap); send_byte(8'h02, gap);
    send_byte(8'h11, gap); send_byte(8'h22, gap); send_byte(8'h21, 0);
  endtask

  task automatic pulse_ack;
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (o_fValid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", o_fValid); end
    total++; if (o_Cmd !== 8'h00) begin bad++; $display("FAIL rst_cmd got=%h exp=00", o_Cmd); end
    total++; if (o_Len !== 8'h00) begin bad++; $display("FAIL rst_len got=%h exp=00", o_Len); end
    total++; if (o_ErrCode !== 2'b00) begin bad++; $display("FAIL rst_code got=%b exp=00", o_ErrCode); end
    total++; if ({o_fErr, o_fOvr} !== 2'b00) begin bad++; $display("FAIL rst_strobes got=%b exp=00", {o_fErr, o_fOvr}); end
    for (int a = 0; a < MAXL; a += 5) begin
      rd_addr = 8'(a); #1;
      total++; if (o_RdData !== 8'h00) begin bad++; $display("FAIL rst_buf[%0d] got=%h exp=00", a, o_RdData); end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_good_frame;
    int e0;
    e0 = err_pulses;
    send_byte(8'h55, 1);
    send_frame1(1);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s1_valid got=%b exp=1", o_fValid); end
    total++; if (o_Cmd !== 8'h10) begin bad++; $display("FAIL s1_cmd got=%h exp=10", o_Cmd); end
    total++; if (o_Len !== 8'h02) begin bad++; $display("FAIL s1_len got=%h exp=02", o_Len); end
    rd_addr = 8'd0; #1;
    total++; if (o_RdData !== 8'h11) begin bad++; $display("FAIL s1_rd0 got=%h exp=11", o_RdData); end
    rd_addr = 8'd1; #1;
    total++; if (o_RdData !== 8'h22) begin bad++; $display("FAIL s1_rd1 got=%h exp=22", o_RdData); end
    rd_addr = 8'(MAXL); #1;
    total++; if (o_RdData !== 8'h00) begin bad++; $display("FAIL s1_rd_oob got=%h exp=00", o_RdData); end
    @(negedge clk);
    total++; if (err_pulses != e0) begin bad++; $display("FAIL s1_no_err got=%0d exp=%0d", err_pulses, e0); end
    pulse_ack;
    total++; if (o_fValid !== 1'b0) begin bad++; $display("FAIL s1_ack_valid got=%b exp=0", o_fValid); end
  endtask

  task automatic test_bad_chk;
    int e0;
    e0 = err_pulses;
    send_byte(8'hAA, 0); send_byte(8'h10, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h20, 0);
    total++; if (o_fErr !== 1'b1) begin bad++; $display("FAIL s2_err got=%b exp=1", o_fErr); end
    total++; if (o_ErrCode !== 2'b01) begin bad++; $display("FAIL s2_code got=%b exp=01", o_ErrCode); end
    last_err = 2'b01;
    @(negedge clk);
    total++; if (err_pulses - e0 != 1) begin bad++; $display("FAIL s2_pulses got=%0d exp=1", err_pulses - e0); end
    total++; if (o_fValid !== 1'b0) begin bad++; $display("FAIL s2_valid got=%b exp=0", o_fValid); end
    send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s2_next_valid got=%b exp=1", o_fValid); end
    total++; if (o_ErrCode !== last_err) begin bad++; $display("FAIL s2_code_held got=%b exp=%b", o_ErrCode, last_err); end
    pulse_ack;
  endtask

  task automatic test_len;
    logic [7:0] x;
    send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s3_valid got=%b exp=1", o_fValid); end
    total++; if (o_Cmd !== 8'h05) begin bad++; $display("FAIL s3_cmd got=%h exp=05", o_Cmd); end
    total++; if (o_Len !== 8'h00) begin bad++; $display("FAIL s3_len got=%h exp=00", o_Len); end
    pulse_ack;
    send_byte(8'hAA, 0); send_byte(8'h01, 0); send_byte(8'h11, 0);
    total++; if (o_fErr !== 1'b1) begin bad++; $display("FAIL s3_len_err got=%b exp=1", o_fErr); end
    total++; if (o_ErrCode !== 2'b10) begin bad++; $display("FAIL s3_len_code got=%b exp=10", o_ErrCode); end
    last_err = 2'b10;
    // Length exactly at the buffer depth is accepted.
    x = 8'h33 ^ 8'(MAXL);
    send_byte(8'hAA, 0); send_byte(8'h33, 0); send_byte(8'(MAXL), 0);
    for (int i = 0; i < MAXL; i++) begin
      send_byte(8'(i * 17 + 1), 0);
      x = x ^ 8'(i * 17 + 1);
    end
    send_byte(x, 0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s3_maxlen_valid got=%b exp=1", o_fValid); end
    rd_addr = 8'(MAXL - 1); #1;
    total++; if (o_RdData !== 8'((MAXL - 1) * 17 + 1)) begin bad++; $display("FAIL s3_maxlen_last got=%h exp=%h", o_RdData, 8'((MAXL - 1) * 17 + 1)); end
    @(negedge clk);
    pulse_ack;
  endtask

  task automatic test_timeout;
    int first;
    int e0;
    send_byte(8'hAA, 0); send_byte(8'h10, 0);
    first = -1;
    for (int c = 1; c <= TMO + 20; c++) begin
      @(negedge clk);
      if (first < 0 && o_fErr) first = c;
    end
    total++; if (first != TMO) begin bad++; $display("FAIL s4_tmo_cycle got=%0d exp=%0d", first, TMO); end
    total++; if (o_ErrCode !== 2'b11) begin bad++; $display("FAIL s4_tmo_code got=%b exp=11", o_ErrCode); end
    last_err = 2'b11;
    send_byte(8'hAA, 0); send_byte(8'h05, 0); send_byte(8'h00, 0); send_byte(8'h05, 0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s4_after_valid got=%b exp=1", o_fValid); end
    pulse_ack;
    // A byte landing in the expiry cycle keeps the frame alive.
    e0 = err_pulses;
    send_byte(8'hAA, 0); send_byte(8'h10, TMO - 1); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0); send_byte(8'h21, 0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s4_edge_valid got=%b exp=1", o_fValid); end
    @(negedge clk);
    total++; if (err_pulses != e0) begin bad++; $display("FAIL s4_edge_err got=%0d exp=%0d", err_pulses, e0); end
    pulse_ack;
  endtask

  task automatic test_back_to_back;
    int o0;
    send_frame1(0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s5_valid got=%b exp=1", o_fValid); end
    o0 = ovr_pulses;
    send_byte(8'hAA, 0);
    total++; if (o_fOvr !== 1'b1) begin bad++; $display("FAIL s5_ovr got=%b exp=1", o_fOvr); end
    total++; if (o_Cmd !== 8'h10) begin bad++; $display("FAIL s5_cmd_frozen got=%h exp=10", o_Cmd); end
    @(negedge clk);
    total++; if (ovr_pulses - o0 != 1) begin bad++; $display("FAIL s5_ovr_pulses got=%0d exp=1", ovr_pulses - o0); end
    ack = 1'b1; fbyte = 1'b1; byte_v = 8'hAA;
    @(negedge clk);
    ack = 1'b0; fbyte = 1'b0;
    total++; if ({o_fValid, o_fOvr} !== 2'b00) begin bad++; $display("FAIL s5_handover got=%b exp=00", {o_fValid, o_fOvr}); end
    send_byte(8'h07, 0); send_byte(8'h00, 0); send_byte(8'h07, 0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s5_new_valid got=%b exp=1", o_fValid); end
    total++; if (o_Cmd !== 8'h07) begin bad++; $display("FAIL s5_new_cmd got=%h exp=07", o_Cmd); end
    pulse_ack;
  endtask

  task automatic test_reset_midframe;
    send_byte(8'hAA, 0); send_byte(8'h10, 0); send_byte(8'h02, 0);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    rd_addr = 8'd0;
    #2 rst_n = 1'b0;
    #1;
    total++; if ({o_fValid, o_fErr, o_fOvr} !== 3'b000) begin bad++; $display("FAIL s6_strobes got=%b exp=000", {o_fValid, o_fErr, o_fOvr}); end
    total++; if (o_Cmd !== 8'h00) begin bad++; $display("FAIL s6_cmd got=%h exp=00", o_Cmd); end
    total++; if (o_Len !== 8'h00) begin bad++; $display("FAIL s6_len got=%h exp=00", o_Len); end
    total++; if (o_ErrCode !== 2'b00) begin bad++; $display("FAIL s6_code got=%b exp=00", o_ErrCode); end
    total++; if (o_RdData !== 8'h00) begin bad++; $display("FAIL s6_buf got=%h exp=00", o_RdData); end
    last_err = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_frame1(0);
    total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL s6_after_valid got=%b exp=1", o_fValid); end
    rd_addr = 8'd1; #1;
    total++; if (o_RdData !== 8'h22) begin bad++; $display("FAIL s6_after_rd1 got=%h exp=22", o_RdData); end
    @(negedge clk);
    pulse_ack;
  endtask

  task automatic test_random;
    logic [7:0] cmd, len, chk, x, g;
    logic [7:0] pl [MAXL];
    int kind, ng, e0;
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 2);
      cmd = 8'($urandom);
      len = (kind == 2) ? 8'($urandom_range(MAXL + 1, 255)) : 8'($urandom_range(0, MAXL));
      for (int i = 0; i < MAXL; i++) pl[i] = 8'($urandom);
      // Reference checksum: XOR of CMD, LEN and the payload bytes.
      x = cmd ^ len;
      for (int i = 0; i < int'(len) && i < MAXL; i++) x = x ^ pl[i];
      chk = (kind == 1) ? (x ^ 8'($urandom_range(1, 255))) : x;
      e0 = err_pulses;
      ng = $urandom_range(0, 2);
      for (int i = 0; i < ng; i++) begin
        g = 8'($urandom);
        if (g == 8'hAA) g = 8'h3C;
        send_byte(g, $urandom_range(0, 3));
      end
      send_byte(8'hAA, $urandom_range(0, 3));
      ack = ($urandom_range(0, 3) == 0);
      send_byte(cmd, 0);
      ack = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (int'(len) > MAXL) begin
        send_byte(len, 0);
      end else begin
        send_byte(len, $urandom_range(0, 3));
        for (int i = 0; i < int'(len); i++) send_byte(pl[i], $urandom_range(0, 3));
        send_byte(chk, 0);
      end
      if (int'(len) > MAXL || chk != x) begin
        last_err = (int'(len) > MAXL) ? 2'b10 : 2'b01;
        total++; if (o_fErr !== 1'b1) begin bad++; $display("FAIL rnd%0d_err got=%b exp=1", f, o_fErr); end
        total++; if (o_ErrCode !== last_err) begin bad++; $display("FAIL rnd%0d_code got=%b exp=%b", f, o_ErrCode, last_err); end
        total++; if (o_fValid !== 1'b0) begin bad++; $display("FAIL rnd%0d_valid got=%b exp=0", f, o_fValid); end
        @(negedge clk);
      end else begin
        total++; if (o_fValid !== 1'b1) begin bad++; $display("FAIL rnd%0d_valid got=%b exp=1", f, o_fValid); end
        total++; if (o_Cmd !== cmd) begin bad++; $display("FAIL rnd%0d_cmd got=%h exp=%h", f, o_Cmd, cmd); end
        total++; if (o_Len !== len) begin bad++; $display("FAIL rnd%0d_len got=%h exp=%h", f, o_Len, len); end
        total++; if (o_ErrCode !== last_err) begin bad++; $display("FAIL rnd%0d_code_held got=%b exp=%b", f, o_ErrCode, last_err); end
        for (int i = 0; i < int'(len); i++) begin
          rd_addr = 8'(i); #1;
          total++; if (o_RdData !== pl[i]) begin bad++; $display("FAIL rnd%0d_rd%0d got=%h exp=%h", f, i, o_RdData, pl[i]); end
        end
        rd_addr = 8'($urandom_range(MAXL, 255)); #1;
        total++; if (o_RdData !== 8'h00) begin bad++; $display("FAIL rnd%0d_rd_oob got=%h exp=00", f, o_RdData); end
        @(negedge clk);
        total++; if (err_pulses != e0) begin bad++; $display("FAIL rnd%0d_no_err got=%0d exp=%0d", f, err_pulses, e0); end
        pulse_ack;
        total++; if (o_fValid !== 1'b0) begin bad++; $display("FAIL rnd%0d_ack got=%b exp=0", f, o_fValid); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_good_frame;
    test_bad_chk;
    test_len;
    test_timeout;
    test_back_to_back;
    test_reset_midframe;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
